// File: rtl/mmio_io_responder_pkg.sv
// Shared bus definitions for the LEGv8 memory-mapped I/O responder:
// access sizes, register offsets, CTRL bit positions and the size-to-byte-lane mask.
package mmio_io_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_WORD  = 2'b10,
        SIZE_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        OFF_LED   = 2'd0,
        OFF_SW    = 2'd1,
        OFF_COUNT = 2'd2,
        OFF_CTRL  = 2'd3
    } reg_off_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MATCH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] mask;
        case (size_e'(size))
            SIZE_BYTE:  mask = 64'h0000_0000_0000_00FF;
            SIZE_HALF:  mask = 64'h0000_0000_0000_FFFF;
            SIZE_WORD:  mask = 64'h0000_0000_FFFF_FFFF;
            default:    mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mmio_io_responder_timer.sv
// Free-running timer behind the COUNT and CTRL registers: prescaler, 32-bit counter,
// compare value, sticky MATCH flag with write-1-to-clear, and the interrupt output.
module mmio_io_responder_timer
    import mmio_io_responder_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        count_we,
    input  logic        ctrl_we,
    input  logic [63:0] wdata,
    input  logic [63:0] wmask,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        en,
    output logic        match,
    output logic        irq_en,
    output logic        irq
);

    logic [31:0] presc;
    logic        en_next;
    logic        tick;
    logic        w1c;
    logic        match_pend;

    // A tick is dropped when the same edge's CTRL write turns the timer off.
    always_comb begin
        en_next = en;
        if (ctrl_we && wmask[CTRL_EN]) begin
            en_next = wdata[CTRL_EN];
        end
        tick = en && en_next && (presc == 32'(PRESCALE - 1));
        w1c  = ctrl_we && wmask[CTRL_MATCH] && wdata[CTRL_MATCH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc      <= '0;
            count      <= '0;
            cmp        <= '0;
            en         <= 1'b0;
            irq_en     <= 1'b0;
            match      <= 1'b0;
            match_pend <= 1'b0;
        end else begin
            if (count_we) begin
                count <= (count & ~wmask[31:0]) | (wdata[31:0] & wmask[31:0]);
                presc <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
                presc <= '0;
            end else if (en && en_next) begin
                presc <= presc + 32'd1;
            end

            // MATCH follows one cycle behind the increment that lands on CMP.
            match_pend <= tick && !count_we && ((count + 32'd1) == cmp);
            if (match_pend) begin
                match <= 1'b1;
            end else if (w1c) begin
                match <= 1'b0;
            end

            if (ctrl_we) begin
                en  <= en_next;
                cmp <= (cmp & ~wmask[63:32]) | (wdata[63:32] & wmask[63:32]);
                if (wmask[CTRL_IRQ_EN]) begin
                    irq_en <= wdata[CTRL_IRQ_EN];
                end
            end
        end
    end

    assign irq = match & irq_en;

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-bus target exposing LED, switch, timer count and timer control registers
// in a 32-byte window; zero-latency reads onto the shared tri-state data bus.
module mmio_io_responder
    import mmio_io_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int          PRESCALE  = 1,
    parameter int          SW_W      = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     address,
    inout  wire  [63:0]     data,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      size,
    input  logic [SW_W-1:0] sw_in,
    output logic [SW_W-1:0] led_out,
    output logic            irq
);

    logic            sel;
    logic [1:0]      offset;
    logic [63:0]     mask;
    logic [63:0]     wdata;
    logic [63:0]     rdata;
    logic            wr;
    logic            drive;
    logic [SW_W-1:0] led;
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic [31:0]     count;
    logic [31:0]     cmp;
    logic            en;
    logic            match;
    logic            irq_en;

    assign wdata = data;

    // Unaligned accesses fall outside the select and are ignored entirely.
    always_comb begin
        sel    = (address[31:5] == BASE_ADDR[31:5]) && (address[2:0] == 3'b000);
        offset = address[4:3];
        mask   = size_mask(size);
        wr     = mem_write && sel;
        drive  = reset && mem_read && sel && !mem_write;
        case (reg_off_e'(offset))
            OFF_LED:   rdata = 64'(led);
            OFF_SW:    rdata = 64'(sw_sync);
            OFF_COUNT: rdata = {32'd0, count};
            default:   rdata = {cmp, 29'd0, irq_en, match, en};
        endcase
        rdata = rdata & mask;
    end

    assign data = drive ? rdata : 64'bz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led     <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (wr && (reg_off_e'(offset) == OFF_LED)) begin
                led <= (led & ~mask[SW_W-1:0]) | (wdata[SW_W-1:0] & mask[SW_W-1:0]);
            end
        end
    end

    assign led_out = led;

    mmio_io_responder_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .count_we (wr && (reg_off_e'(offset) == OFF_COUNT)),
        .ctrl_we  (wr && (reg_off_e'(offset) == OFF_CTRL)),
        .wdata    (wdata),
        .wmask    (mask),
        .count    (count),
        .cmp      (cmp),
        .en       (en),
        .match    (match),
        .irq_en   (irq_en),
        .irq      (irq)
    );

endmodule
